// File: rtl/spi_slave_stream.sv
// SPI slave that turns MOSI words into an AXI-Stream master and feeds MISO
// from an AXI-Stream slave; SPI pins are oversampled and edge-detected on aclk.
`timescale 1ns/1ps
module spi_slave_stream #(
  parameter int SPI_CPOL = 0,
  parameter int SPI_CPHA = 0,
  parameter int SPI_FSB = 0,
  parameter int SPI_TL = 16,
  parameter int SYNC_STAGES = 2,
  parameter logic [SPI_TL-1:0] TX_IDLE = '1
) (
  input  logic aclk,
  input  logic aresetn,
  output logic axis_m_tvalid,
  input  logic axis_m_tready,
  output logic [SPI_TL-1:0] axis_m_tdata,
  output logic axis_m_tlast,
  input  logic axis_s_tvalid,
  output logic axis_s_tready,
  input  logic [SPI_TL-1:0] axis_s_tdata,
  input  logic spi_s_sck,
  input  logic spi_s_csn,
  input  logic spi_s_mosi,
  output logic spi_s_miso,
  input  logic status_clr,
  output logic rx_overflow,
  output logic tx_underrun,
  output logic frame_error
);

  localparam int CW = $clog2(SPI_TL);
  localparam logic [CW-1:0] LAST = CW'(SPI_TL - 1);
  localparam logic CPOL_B = (SPI_CPOL != 0);
  localparam logic CPHA_B = (SPI_CPHA != 0);
  localparam logic FSB_B = (SPI_FSB != 0);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sr, csn_sr, mosi_sr;
  logic sck_prev, csn_prev;
  logic sck_cur, csn_cur, mosi_cur;
  logic lead, trail, live, smp, shf;
  logic csn_fall, csn_rise, start, stop;
  logic [CW-1:0] cnt;
  logic wrap, load, emit, m_busy;
  logic pend_valid;
  logic [SPI_TL-1:0] rx_sh, rx_next, pend_data;
  logic [SPI_TL-1:0] tx_sh, tx_buf, tx_shifted, load_word;
  logic tx_bit;

  // CSN sync resets low so a frame cut by reset needs a fresh high->low.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sck_sr <= {SYNC_STAGES{CPOL_B}};
      csn_sr <= '0;
      mosi_sr <= '0;
      sck_prev <= CPOL_B;
      csn_prev <= 1'b0;
    end else begin
      sck_sr <= {sck_sr[SYNC_STAGES-2:0], spi_s_sck};
      csn_sr <= {csn_sr[SYNC_STAGES-2:0], spi_s_csn};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_s_mosi};
      sck_prev <= sck_sr[SYNC_STAGES-1];
      csn_prev <= csn_sr[SYNC_STAGES-1];
    end
  end

  assign sck_cur = sck_sr[SYNC_STAGES-1];
  assign csn_cur = csn_sr[SYNC_STAGES-1];
  assign mosi_cur = mosi_sr[SYNC_STAGES-1];

  assign lead = (sck_prev == CPOL_B) && (sck_cur != CPOL_B);
  assign trail = (sck_prev != CPOL_B) && (sck_cur == CPOL_B);
  assign live = (state == ACTIVE) && !csn_cur;
  assign smp = live && (CPHA_B ? trail : lead);
  assign shf = live && (CPHA_B ? lead : trail);

  assign csn_fall = csn_prev && !csn_cur;
  assign csn_rise = !csn_prev && csn_cur;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    start = 1'b0;
    stop = 1'b0;
    unique case (state)
      IDLE: begin
        if (csn_fall) begin
          state_nx = ACTIVE;
          start = 1'b1;
        end
      end
      ACTIVE: begin
        if (csn_rise) begin
          state_nx = IDLE;
          stop = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign wrap = smp && (cnt == LAST);
  assign load = start || wrap;
  assign load_word = axis_s_tvalid ? axis_s_tdata : TX_IDLE;
  assign axis_s_tready = aresetn && load && axis_s_tvalid;

  assign rx_next = FSB_B ? {rx_sh[SPI_TL-2:0], mosi_cur}
                         : {mosi_cur, rx_sh[SPI_TL-1:1]};

  assign emit = pend_valid && (smp || stop);
  assign m_busy = axis_m_tvalid && !axis_m_tready;

  assign tx_shifted = FSB_B ? {tx_sh[SPI_TL-2:0], 1'b0}
                            : {1'b0, tx_sh[SPI_TL-1:1]};
  assign tx_bit = FSB_B ? tx_sh[SPI_TL-1] : tx_sh[0];
  assign spi_s_miso = (state == ACTIVE) && tx_bit;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt <= '0;
      rx_sh <= '0;
      pend_valid <= 1'b0;
      pend_data <= '0;
      axis_m_tvalid <= 1'b0;
      axis_m_tdata <= '0;
      axis_m_tlast <= 1'b0;
      tx_sh <= '0;
      tx_buf <= '0;
    end else begin
      if (axis_m_tready) begin
        axis_m_tvalid <= 1'b0;
      end
      if (emit && !m_busy) begin
        axis_m_tvalid <= 1'b1;
        axis_m_tdata <= pend_data;
        axis_m_tlast <= stop;
      end
      if (start) begin
        cnt <= '0;
        pend_valid <= 1'b0;
        tx_sh <= load_word;
        tx_buf <= load_word;
      end
      if (stop) begin
        pend_valid <= 1'b0;
      end
      if (smp) begin
        cnt <= wrap ? '0 : cnt + CW'(1);
        rx_sh <= rx_next;
        if (pend_valid) begin
          pend_valid <= 1'b0;
        end
        if (wrap) begin
          pend_valid <= 1'b1;
          pend_data <= rx_next;
          tx_buf <= load_word;
        end
      end
      // Word boundary: the staged word replaces the drained shifter.
      if (shf) begin
        tx_sh <= (cnt == '0) ? tx_buf : tx_shifted;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_overflow <= (rx_overflow && !status_clr) || (emit && m_busy);
      tx_underrun <= (tx_underrun && !status_clr) || (load && !axis_s_tvalid);
      frame_error <= (frame_error && !status_clr) || (stop && (cnt != '0));
    end
  end

endmodule
